// File: rtl/sim_exit_controller_pkg.sv
// Shared types and exit codes for the simulation exit controller.
package sim_exit_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        VK_NONE,
        VK_PASS,
        VK_FAIL,
        VK_TIMEOUT,
        VK_HANG
    } verdict_e;

    localparam logic [7:0] EXIT_PASS      = 8'h00;
    localparam logic [7:0] EXIT_FAIL_ANON = 8'h01;
    localparam logic [7:0] EXIT_HANG      = 8'h7E;
    localparam logic [7:0] EXIT_TIMEOUT   = 8'h7F;

    // Index width for n sources; a single source still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sim_exit_controller_prio_enc.sv
// Lowest-index-wins priority encoder returning a valid flag and the winning index.
module sim_exit_prio_enc #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sim_exit_controller.sv
// Reset/run/exit sequencer producing a single pass/fail/timeout verdict for a simulated SoC.
// Optional heartbeat hang detection is enabled by defining SIM_EXIT_HEARTBEAT_EN.
module sim_exit_controller
    import sim_exit_pkg::*;
#(
    parameter int unsigned N_SRC        = 4,
    parameter int unsigned CYCLE_W      = 64,
    parameter int unsigned RESET_HOLD   = 16,
    parameter int unsigned DRAIN_CYCLES = 8,
    parameter int unsigned CODE_W       = 8
`ifdef SIM_EXIT_HEARTBEAT_EN
    ,
    parameter int unsigned HB_LIMIT     = 4096
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [CYCLE_W-1:0]            max_cycles,
    input  logic [N_SRC-1:0]              src_success,
    input  logic [N_SRC-1:0]              src_fail,
    input  logic [N_SRC*CODE_W-1:0]       src_fail_code,
`ifdef SIM_EXIT_HEARTBEAT_EN
    input  logic [N_SRC-1:0]              src_heartbeat,
`endif
    output logic                          core_reset,
    output logic                          running,
    output logic                          done,
    output logic                          pass,
    output logic [CODE_W-1:0]             exit_code,
    output logic [idx_w(N_SRC)-1:0]       fail_src,
    output logic [CYCLE_W-1:0]            cycle_count
);

    localparam int unsigned IDX_W = idx_w(N_SRC);

    state_e               state_q, state_d;
    logic [31:0]          hold_q, hold_d;
    logic [31:0]          drain_q, drain_d;
    logic [CYCLE_W-1:0]   lim_q, lim_d;
    logic [CYCLE_W-1:0]   cnt_q, cnt_d;
    logic [N_SRC-1:0]     succ_seen_q, succ_seen_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic [IDX_W-1:0]     fsrc_q, fsrc_d;

    logic                 fail_vld;
    logic [IDX_W-1:0]     fail_idx;
    logic [CODE_W-1:0]    fail_code;
    logic                 hang;
    verdict_e             kind;

    sim_exit_prio_enc #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_fail_enc (
        .req   (src_fail),
        .valid (fail_vld),
        .idx   (fail_idx)
    );

    always_comb begin
        fail_code = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (IDX_W'(i) == fail_idx) begin
                fail_code = src_fail_code[i*CODE_W +: CODE_W];
            end
        end
    end

`ifdef SIM_EXIT_HEARTBEAT_EN
    logic [31:0] hb_q, hb_d, hb_next;

    always_comb begin
        hb_next = (|src_heartbeat) ? '0 : hb_q + 32'd1;
        hb_d    = (state_q == RUN) ? hb_next : hb_q;
        hang    = (state_q == RUN) && (hb_next == HB_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) hb_q <= '0;
        else       hb_q <= hb_d;
    end
`else
    assign hang = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        drain_d     = drain_q;
        lim_d       = lim_q;
        cnt_d       = cnt_q;
        succ_seen_d = succ_seen_q;
        pass_d      = pass_q;
        code_d      = code_q;
        fsrc_d      = fsrc_q;
        kind        = VK_NONE;
        // done is registered off the DONE state, adding the one-cycle verdict latch to the drain time.
        done_d      = (state_q == DONE);

        unique case (state_q)
            HOLD: begin
                if (hold_q == RESET_HOLD - 1) begin
                    lim_d   = max_cycles;
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            RUN: begin
                cnt_d       = cnt_q + CYCLE_W'(1);
                succ_seen_d = succ_seen_q | src_success;
                if (fail_vld) begin
                    kind = VK_FAIL;
                end else if (hang) begin
                    kind = VK_HANG;
                end else if ((lim_q != '0) && (cnt_q == lim_q - CYCLE_W'(1))) begin
                    kind = VK_TIMEOUT;
                end else if ((succ_seen_q | src_success) == '1) begin
                    kind = VK_PASS;
                end

                if (kind != VK_NONE) begin
                    state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                    drain_d = '0;
                    pass_d  = (kind == VK_PASS);
                    unique case (kind)
                        VK_FAIL: begin
                            code_d = (fail_code == '0) ? CODE_W'(EXIT_FAIL_ANON) : fail_code;
                            fsrc_d = fail_idx;
                        end
                        VK_HANG:    code_d = CODE_W'(EXIT_HANG);
                        VK_TIMEOUT: code_d = CODE_W'(EXIT_TIMEOUT);
                        default:    code_d = CODE_W'(EXIT_PASS);
                    endcase
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_CYCLES - 1) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 32'd1;
                end
            end
            DONE: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HOLD;
            hold_q      <= '0;
            drain_q     <= '0;
            lim_q       <= '0;
            cnt_q       <= '0;
            succ_seen_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            code_q      <= '0;
            fsrc_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            drain_q     <= drain_d;
            lim_q       <= lim_d;
            cnt_q       <= cnt_d;
            succ_seen_q <= succ_seen_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            code_q      <= code_d;
            fsrc_q      <= fsrc_d;
        end
    end

    assign core_reset  = (state_q == HOLD) || (state_q == DONE);
    assign running     = (state_q == RUN);
    assign done        = done_q;
    assign pass        = pass_q;
    assign exit_code   = code_q;
    assign fail_src    = fsrc_q;
    assign cycle_count = cnt_q;

endmodule
